// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM operand sequencer.
// Holds the sequencer state encoding, the default datapath widths and the
// sign extension used to fold tree results into the C accumulator.
package gemm_pkg;

   localparam int unsigned N      = 8;
   localparam int unsigned WIDTH  = 16;
   localparam int unsigned ACC_W  = 40;
   localparam int unsigned DIM_W  = 8;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned VEC_W  = N * WIDTH;
   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } seq_state_t;

   // Sign-extend a partial dot product to accumulator width.
   function automatic logic [ACC_W-1:0] sext_acc(input logic [PROD_W-1:0] x);
      return {{(ACC_W-PROD_W){x[PROD_W-1]}}, x};
   endfunction

endpackage

// File: rtl/gemm_operand_sequencer_if.sv
// C result stream of the GEMM operand sequencer (valid/ready).
//   c_valid : C element available        c_ready : downstream accept
//   c_data  : signed C element           c_row/c_col : element indices
interface gemm_operand_sequencer_if;
   import gemm_pkg::*;

   logic             c_valid;
   logic             c_ready;
   logic [ACC_W-1:0] c_data;
   logic [DIM_W-1:0] c_row;
   logic [DIM_W-1:0] c_col;

   modport master (output c_valid, c_data, c_row, c_col, input c_ready);
   modport slave  (input c_valid, c_data, c_row, c_col, output c_ready);

endinterface

// File: rtl/gemm_addr_gen.sv
// Row/column/chunk counters and operand addresses for the sequencer.
// Addresses come from running bases (no multipliers):
//   a_addr = a_base + k, a_base advances by k_len per row
//   b_addr = b_base + k, b_base advances by k_len per column
// Ports: load clears everything for a new job, step_k advances one chunk,
// next_elem moves to the next C element in row-major order. The *_c flags
// are combinational decodes of the counters.
module gemm_addr_gen
   import gemm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step_k,
   input  logic              next_elem,
   input  logic [DIM_W-1:0]  m_len,
   input  logic [DIM_W-1:0]  n_len,
   input  logic [DIM_W-1:0]  k_len,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DIM_W-1:0]  row,
   output logic [DIM_W-1:0]  col,
   output logic              k_last_c,
   output logic              col_last_c,
   output logic              row_last_c
);

   logic [DIM_W-1:0]  k;
   logic [ADDR_W-1:0] a_base;
   logic [ADDR_W-1:0] b_base;
   logic [ADDR_W-1:0] k_step;

   assign k_step     = ADDR_W'(k_len);
   assign k_last_c   = (k   == k_len - DIM_W'(1));
   assign col_last_c = (col == n_len - DIM_W'(1));
   assign row_last_c = (row == m_len - DIM_W'(1));

   // Counter and base update; a new job restarts from the origin.
   always_ff @(posedge clk) begin
      if (!rst || load) begin
         k      <= '0;
         row    <= '0;
         col    <= '0;
         a_base <= '0;
         b_base <= '0;
         a_addr <= '0;
         b_addr <= '0;
      end else if (step_k) begin
         k      <= k + DIM_W'(1);
         a_addr <= a_addr + ADDR_W'(1);
         b_addr <= b_addr + ADDR_W'(1);
      end else if (next_elem) begin
         k <= '0;
         if (col_last_c) begin
            // Column wrap: back to B column 0, next A row.
            col    <= '0;
            row    <= row + DIM_W'(1);
            b_base <= '0;
            b_addr <= '0;
            a_base <= a_base + k_step;
            a_addr <= a_base + k_step;
         end else begin
            col    <= col + DIM_W'(1);
            b_base <= b_base + k_step;
            b_addr <= b_base + k_step;
            a_addr <= a_base;
         end
      end
   end

endmodule

// File: rtl/gemm_operand_sequencer.sv
// Feeds A-row / B-column chunk pairs to the MAC adder tree, accumulates the
// tree's partial dot products and emits one C element per (row, col).
// Ports: start/m_dim/n_dim/k_chunks launch a job; busy/done report it;
// a_rd_*/b_rd_* read the operand buffers (1-cycle latency); vec_a/vec_b/
// mac_in_valid drive the tree; mac_result/mac_out_valid return from it;
// c carries the C result stream.
module gemm_operand_sequencer
   import gemm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  m_dim,
   input  logic [DIM_W-1:0]  n_dim,
   input  logic [DIM_W-1:0]  k_chunks,
   output logic              busy,
   output logic              done,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   input  logic [VEC_W-1:0]  a_rd_data,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_rd_addr,
   input  logic [VEC_W-1:0]  b_rd_data,
   output logic [VEC_W-1:0]  vec_a,
   output logic [VEC_W-1:0]  vec_b,
   output logic              mac_in_valid,
   input  logic [PROD_W-1:0] mac_result,
   input  logic              mac_out_valid,
   gemm_operand_sequencer_if.master c
);

   seq_state_t       state;
   logic [DIM_W-1:0] m_len, n_len, k_len;
   logic [DIM_W-1:0] beats, beats_next;
   logic [ACC_W-1:0] acc, acc_next;
   logic [DIM_W-1:0] row, col;
   logic             k_last_c, col_last_c, row_last_c;
   logic             dims_zero, load, beat, handshake;

   assign dims_zero  = (m_dim == '0) || (n_dim == '0) || (k_chunks == '0);
   assign load       = (state == IDLE) && start && !dims_zero;
   assign handshake  = (state == OUT) && c.c_ready;
   assign beat       = mac_out_valid && ((state == ISSUE) || (state == WAIT));
   assign acc_next   = acc + sext_acc(mac_result);
   assign beats_next = beats + DIM_W'(1);
   assign b_rd_en    = a_rd_en;

   // Buffer outputs are already registered; gating by mac_in_valid keeps the
   // tree inputs aligned with the strobe-delayed valid and zero when idle.
   assign vec_a = mac_in_valid ? a_rd_data : '0;
   assign vec_b = mac_in_valid ? b_rd_data : '0;

   gemm_addr_gen u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .step_k     (state == ISSUE),
      .next_elem  (handshake),
      .m_len      (m_len),
      .n_len      (n_len),
      .k_len      (k_len),
      .a_addr     (a_rd_addr),
      .b_addr     (b_rd_addr),
      .row        (row),
      .col        (col),
      .k_last_c   (k_last_c),
      .col_last_c (col_last_c),
      .row_last_c (row_last_c)
   );

   // Sequencer FSM, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         m_len        <= '0;
         n_len        <= '0;
         k_len        <= '0;
         beats        <= '0;
         acc          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         a_rd_en      <= 1'b0;
         mac_in_valid <= 1'b0;
         c.c_valid    <= 1'b0;
         c.c_data     <= '0;
         c.c_row      <= '0;
         c.c_col      <= '0;
      end else begin
         done         <= 1'b0;
         mac_in_valid <= a_rd_en;
         case (state)
            IDLE: begin
               if (start) begin
                  m_len <= m_dim;
                  n_len <= n_dim;
                  k_len <= k_chunks;
                  if (dims_zero) begin
                     done <= 1'b1;
                  end else begin
                     busy    <= 1'b1;
                     a_rd_en <= 1'b1;
                     acc     <= '0;
                     beats   <= '0;
                     state   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // Long k_chunks lets early beats land while reads continue.
               if (beat) begin
                  acc   <= acc_next;
                  beats <= beats_next;
               end
               if (k_last_c) begin
                  a_rd_en <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (beat) begin
                  acc   <= acc_next;
                  beats <= beats_next;
                  if (beats_next == k_len) begin
                     c.c_valid <= 1'b1;
                     c.c_data  <= acc_next;
                     c.c_row   <= row;
                     c.c_col   <= col;
                     state     <= OUT;
                  end
               end
            end
            OUT: begin
               if (c.c_ready) begin
                  c.c_valid <= 1'b0;
                  acc       <= '0;
                  beats     <= '0;
                  if (row_last_c && col_last_c) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     a_rd_en <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gemm_operand_sequencer.sv
// Bench for gemm_operand_sequencer: behavioural 1-cycle operand buffers, a
// 3-cycle dot-product tree model, a job table with hand-computed results and
// directed sequences for zero dims and reset during WAIT.
module tb_gemm_operand_sequencer;
   import gemm_pkg::*;

   localparam int unsigned MAC_LAT = 3;
   localparam int unsigned DEPTH   = 1 << ADDR_W;

   typedef struct {
      int               m;
      int               n;
      int               k;
      int               pat;
      int               stall;
      bit               poke;
      logic [ACC_W-1:0] exp_first;
      int               exp_n;
   } job_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [DIM_W-1:0]  m_dim, n_dim, k_chunks;
   logic              busy, done;
   logic              a_rd_en, b_rd_en;
   logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
   logic [VEC_W-1:0]  a_rd_data = '0;
   logic [VEC_W-1:0]  b_rd_data = '0;
   logic [VEC_W-1:0]  vec_a, vec_b;
   logic              mac_in_valid;
   logic [PROD_W-1:0] mac_result;
   logic              mac_out_valid;

   logic [VEC_W-1:0]   a_mem [DEPTH];
   logic [VEC_W-1:0]   b_mem [DEPTH];
   logic [MAC_LAT-1:0] v_pipe = '0;
   logic [PROD_W-1:0]  r_pipe [MAC_LAT];

   int   rowa [N] = '{5, 7, 4, 1, 9, 2, 3, 6};
   int   colb [N] = '{3, 2, 6, 8, 0, 5, 7, 4};
   job_t jobs [5];
   int   errors = 0;
   int   checks = 0;

   gemm_operand_sequencer_if c_if ();

   gemm_operand_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .m_dim         (m_dim),
      .n_dim         (n_dim),
      .k_chunks      (k_chunks),
      .busy          (busy),
      .done          (done),
      .a_rd_en       (a_rd_en),
      .a_rd_addr     (a_rd_addr),
      .a_rd_data     (a_rd_data),
      .b_rd_en       (b_rd_en),
      .b_rd_addr     (b_rd_addr),
      .b_rd_data     (b_rd_data),
      .vec_a         (vec_a),
      .vec_b         (vec_b),
      .mac_in_valid  (mac_in_valid),
      .mac_result    (mac_result),
      .mac_out_valid (mac_out_valid),
      .c             (c_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PROD_W-1:0] dot_fn(input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
      logic signed [WIDTH-1:0] x, y;
      int s;
      s = 0;
      for (int e = 0; e < int'(N); e++) begin
         x = a[e*WIDTH +: WIDTH];
         y = b[e*WIDTH +: WIDTH];
         s = s + int'(x) * int'(y);
      end
      return PROD_W'(s);
   endfunction

   function automatic logic [ACC_W-1:0] model_c(input int r, input int cc, input int k);
      logic [ACC_W-1:0] s;
      s = '0;
      for (int kk = 0; kk < k; kk++)
         s = s + ACC_W'($signed(dot_fn(a_mem[r*k+kk], b_mem[cc*k+kk])));
      return s;
   endfunction

   // Operand buffers: data one cycle after the strobe.
   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
      if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
   end

   // Tree model: dot product with MAC_LAT cycles of latency, no reset.
   always @(posedge clk) begin
      v_pipe    <= {v_pipe[MAC_LAT-2:0], mac_in_valid};
      r_pipe[0] <= dot_fn(vec_a, vec_b);
      for (int i = 1; i < int'(MAC_LAT); i++) r_pipe[i] <= r_pipe[i-1];
   end
   assign mac_out_valid = v_pipe[MAC_LAT-1];
   assign mac_result    = r_pipe[MAC_LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string p);
      check({p, "_busy"},      64'(busy), 64'(0));
      check({p, "_done"},      64'(done), 64'(0));
      check({p, "_a_rd_en"},   64'(a_rd_en), 64'(0));
      check({p, "_b_rd_en"},   64'(b_rd_en), 64'(0));
      check({p, "_a_rd_addr"}, 64'(a_rd_addr), 64'(0));
      check({p, "_b_rd_addr"}, 64'(b_rd_addr), 64'(0));
      check({p, "_mac_in_v"},  64'(mac_in_valid), 64'(0));
      check({p, "_vec_a"},     64'(|vec_a), 64'(0));
      check({p, "_vec_b"},     64'(|vec_b), 64'(0));
      check({p, "_c_valid"},   64'(c_if.c_valid), 64'(0));
      check({p, "_c_data"},    64'(c_if.c_data), 64'(0));
      check({p, "_c_row"},     64'(c_if.c_row), 64'(0));
      check({p, "_c_col"},     64'(c_if.c_col), 64'(0));
   endtask

   task automatic fill_mem(input job_t j);
      logic [VEC_W-1:0] v;
      for (int r = 0; r < j.m; r++) begin
         for (int e = 0; e < int'(N); e++)
            v[e*WIDTH +: WIDTH] = (j.pat == 1) ? WIDTH'(16'h8000) : WIDTH'(rowa[e] + r);
         for (int kk = 0; kk < j.k; kk++) a_mem[r*j.k+kk] = v;
      end
      for (int cc = 0; cc < j.n; cc++) begin
         for (int e = 0; e < int'(N); e++)
            v[e*WIDTH +: WIDTH] = (j.pat == 1) ? ((e == 0) ? WIDTH'(16'h8000) : WIDTH'(0))
                                               : WIDTH'(colb[e] * (cc + 1));
         for (int kk = 0; kk < j.k; kk++) b_mem[cc*j.k+kk] = v;
      end
   endtask

   task automatic run_job(input job_t j);
      int strobes, run, res, wcnt, e, kk, r, cc;
      bit hs, fin;
      logic [ACC_W-1:0] held_d;
      logic [DIM_W-1:0] held_r, held_c;
      fill_mem(j);
      @(negedge clk);
      m_dim    = DIM_W'(j.m);
      n_dim    = DIM_W'(j.n);
      k_chunks = DIM_W'(j.k);
      start    = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      strobes = 0; run = 0; res = 0; wcnt = 0; hs = 0; fin = 0;
      held_d = '0; held_r = '0; held_c = '0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         if (hs) begin
            c_if.c_ready = 1'b0;
            check("c_valid_drop", 64'(c_if.c_valid), 64'(0));
            if (res == j.exp_n) begin
               check("done_pulse", 64'(done), 64'(1));
               check("busy_clear", 64'(busy), 64'(0));
               fin = 1;
            end
            hs = 0;
         end else if (done) begin
            check("early_done", 64'(done), 64'(0));
         end
         // Start while busy must be ignored.
         start = j.poke && (cyc == 2);
         if (start) begin
            m_dim = 7; n_dim = 7; k_chunks = 7;
         end
         if (a_rd_en) begin
            e  = strobes / j.k;
            kk = strobes % j.k;
            r  = e / j.n;
            cc = e % j.n;
            check("a_rd_addr", 64'(a_rd_addr), 64'(r*j.k + kk));
            check("b_rd_addr", 64'(b_rd_addr), 64'(cc*j.k + kk));
            check("b_rd_en", 64'(b_rd_en), 64'(1));
            strobes++;
            run++;
         end else if (run != 0) begin
            check("burst_len", 64'(run), 64'(j.k));
            run = 0;
         end
         if (c_if.c_valid && !fin) begin
            if (wcnt == 0) begin
               held_d = c_if.c_data; held_r = c_if.c_row; held_c = c_if.c_col;
            end else begin
               check("c_hold_data", 64'(c_if.c_data), 64'(held_d));
               check("c_hold_row", 64'(c_if.c_row), 64'(held_r));
               check("c_hold_col", 64'(c_if.c_col), 64'(held_c));
            end
            if (wcnt < j.stall) begin
               c_if.c_ready = 1'b0;
               wcnt++;
            end else begin
               r  = res / j.n;
               cc = res % j.n;
               check("c_row", 64'(held_r), 64'(r));
               check("c_col", 64'(held_c), 64'(cc));
               check("c_data", 64'(held_d), 64'(model_c(r, cc, j.k)));
               if (res == 0) check("c_first", 64'(held_d), 64'(j.exp_first));
               c_if.c_ready = 1'b1;
               res++;
               wcnt = 0;
               hs   = 1;
            end
         end
         if (!fin) @(negedge clk);
      end
      start = 1'b0;
      check("job_done", 64'(fin), 64'(1));
      check("result_count", 64'(res), 64'(j.exp_n));
      check("strobe_count", 64'(strobes), 64'(j.m * j.n * j.k));
   endtask

   initial begin
      bit seen, late_seen;
      int bad;
      rst = 1'b0; start = 1'b0; m_dim = '0; n_dim = '0; k_chunks = '0;
      c_if.c_ready = 1'b0;
      jobs[0] = '{m:1, n:1, k:1, pat:0, stall:0, poke:1'b0, exp_first:40'd116,        exp_n:1};
      jobs[1] = '{m:1, n:1, k:2, pat:0, stall:0, poke:1'b0, exp_first:40'd232,        exp_n:1};
      jobs[2] = '{m:2, n:2, k:1, pat:0, stall:5, poke:1'b1, exp_first:40'd116,        exp_n:4};
      jobs[3] = '{m:1, n:1, k:8, pat:1, stall:0, poke:1'b0, exp_first:40'd8589934592, exp_n:1};
      jobs[4] = '{m:2, n:3, k:3, pat:0, stall:1, poke:1'b0, exp_first:40'd348,        exp_n:6};

      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_job(jobs[i]);
         repeat (2) @(negedge clk);
      end

      // Zero dimension: done next cycle, no reads, no results.
      m_dim = 1; n_dim = 0; k_chunks = 1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_done", 64'(done), 64'(1));
      check("zero_busy", 64'(busy), 64'(0));
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (a_rd_en || b_rd_en || c_if.c_valid || busy || done) bad++;
      end
      check("zero_no_activity", 64'(bad), 64'(0));

      // Reset while waiting on the tree; the in-flight beat must be dropped.
      fill_mem(jobs[0]);
      m_dim = 1; n_dim = 1; k_chunks = 1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (mac_in_valid) seen = 1;
         else @(negedge clk);
      end
      check("wait_reached", 64'(seen), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort");
      rst = 1'b1;
      bad = 0; late_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (mac_out_valid) late_seen = 1;
         if (c_if.c_valid || busy || done || a_rd_en) bad++;
         @(negedge clk);
      end
      check("late_beat_arrived", 64'(late_seen), 64'(1));
      check("late_beat_ignored", 64'(bad), 64'(0));
      run_job(jobs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
